dsp_mac_sequencer: RTL and testbench



---
 rtl/dsp_mac_sequencer.sv | 108 ++++++++++
 tb/tb_dsp_mac_sequencer.sv | 283 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/dsp_mac_sequencer.sv
// Control stage that runs the fp16 dsp_slice as a MAC: clears the accumulator,
// streams one operand vector into it, drains the pipeline and returns the dot product.
module dsp_mac_sequencer #(
   parameter int unsigned DWIDTH       = 16,
   parameter int unsigned CNT_W        = 16,
   parameter int unsigned CLEAR_CYCLES = 3,
   parameter int unsigned DRAIN_CYCLES = 3
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              s_valid,
   output logic              s_ready,
   input  logic [DWIDTH-1:0] s_a,
   input  logic [DWIDTH-1:0] s_b,
   input  logic              s_last,
   output logic              m_valid,
   input  logic              m_ready,
   output logic [DWIDTH-1:0] m_data,
   output logic [CNT_W-1:0]  m_count,
   output logic [DWIDTH-1:0] dsp_a,
   output logic [DWIDTH-1:0] dsp_b,
   output logic [2:0]        dsp_mode,
   input  logic [DWIDTH-1:0] dsp_c
);

   localparam int unsigned PH_W     = 8;
   localparam logic [2:0]  MODE_ADD = 3'b001;
   localparam logic [2:0]  MODE_MAC = 3'b100;

   typedef enum logic [2:0] {
      IDLE  = 3'd0,
      CLEAR = 3'd1,
      FEED  = 3'd2,
      DRAIN = 3'd3,
      DONE  = 3'd4
   } state_t;

   state_t            state;
   logic [PH_W-1:0]   phase;
   logic [CNT_W-1:0]  count;
   logic              s_fire;

   assign s_fire = s_valid && s_ready;

   // Slice drive is a pure function of the current state; FEED passes operands
   // straight through so a bubble feeds 0*0 and leaves the accumulator untouched.
   assign s_ready  = (state == FEED);
   assign dsp_mode = (state == CLEAR) ? MODE_ADD : MODE_MAC;
   assign dsp_a    = (state == FEED && s_valid) ? s_a : '0;
   assign dsp_b    = (state == FEED && s_valid) ? s_b : '0;

   always_ff @(posedge clk) begin
      if (reset) begin
         state   <= IDLE;
         phase   <= '0;
         count   <= '0;
         m_valid <= 1'b0;
         m_data  <= '0;
         m_count <= '0;
      end else begin
         case (state)
            IDLE: begin
               if (s_valid) begin
                  state <= CLEAR;
                  phase <= '0;
               end
            end
            CLEAR: begin
               if (phase == PH_W'(CLEAR_CYCLES - 1)) begin
                  state <= FEED;
                  phase <= '0;
                  count <= '0;
               end else begin
                  phase <= phase + PH_W'(1);
               end
            end
            FEED: begin
               if (s_fire) begin
                  if (count != '1) count <= count + CNT_W'(1);
                  if (s_last) begin
                     state <= DRAIN;
                     phase <= '0;
                  end
               end
            end
            DRAIN: begin
               // Last drain cycle is the first one where dsp_c includes the final pair.
               if (phase == PH_W'(DRAIN_CYCLES - 1)) begin
                  m_data  <= dsp_c;
                  m_count <= count;
                  m_valid <= 1'b1;
                  state   <= DONE;
               end else begin
                  phase <= phase + PH_W'(1);
               end
            end
            DONE: begin
               if (m_ready) begin
                  m_valid <= 1'b0;
                  state   <= IDLE;
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_dsp_mac_sequencer.sv
// Directed bench for dsp_mac_sequencer with a behavioural fp16 dsp_slice
// (operand flops -> mult register -> accumulator).
module tb_dsp_mac_sequencer;

   logic        clk = 1'b0;
   logic        reset;
   logic        s_valid, s_ready, s_last;
   logic [15:0] s_a, s_b;
   logic        m_valid, m_ready;
   logic [15:0] m_data;
   logic [15:0] m_count;
   logic [15:0] dsp_a, dsp_b, dsp_c;
   logic [2:0]  dsp_mode;

   int errors = 0;
   int checks = 0;

   always #5 clk = ~clk;

   dsp_mac_sequencer dut (
      .clk(clk), .reset(reset),
      .s_valid(s_valid), .s_ready(s_ready), .s_a(s_a), .s_b(s_b), .s_last(s_last),
      .m_valid(m_valid), .m_ready(m_ready), .m_data(m_data), .m_count(m_count),
      .dsp_a(dsp_a), .dsp_b(dsp_b), .dsp_mode(dsp_mode), .dsp_c(dsp_c)
   );

   function automatic real p2(input int k);
      real r = 1.0;
      if (k >= 0) for (int i = 0; i < k; i++) r = r * 2.0;
      else        for (int i = 0; i < -k; i++) r = r / 2.0;
      return r;
   endfunction

   function automatic real h2r(input logic [15:0] h);
      int  e = int'(h[14:10]);
      real m = real'(int'(h[9:0])) / 1024.0;
      real v;
      if (e == 0) v = m * p2(-14);
      else        v = (1.0 + m) * p2(e - 15);
      return h[15] ? -v : v;
   endfunction

   function automatic logic [15:0] r2h(input real r);
      logic s = (r < 0.0);
      real  a = s ? -r : r;
      int   e = 15;
      int   mant;
      if (a == 0.0) return 16'h0000;
      for (int i = 0; i < 40 && a >= 2.0; i++) begin a = a / 2.0; e++; end
      for (int i = 0; i < 40 && a < 1.0 && e > 1; i++) begin a = a * 2.0; e--; end
      mant = $rtoi((a - 1.0) * 1024.0 + 0.5);
      return {s, 5'(e), 10'(mant)};
   endfunction

   // Behavioural slice: add mode sums the operand flops, MAC mode accumulates the product.
   logic [15:0] opa, opb;
   real         mult_r, acc_r;
   always @(posedge clk) begin
      if (reset) begin
         opa <= '0; opb <= '0; mult_r <= 0.0; acc_r <= 0.0;
      end else begin
         opa    <= dsp_a;
         opb    <= dsp_b;
         mult_r <= h2r(opa) * h2r(opb);
         if (dsp_mode == 3'b001) acc_r <= h2r(opa) + h2r(opb);
         else                    acc_r <= acc_r + mult_r;
      end
   end
   always_comb dsp_c = r2h(acc_r);

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // Present a pair and hold it until it transfers; returns 1 ns after the transfer edge.
   task automatic send_pair(input logic [15:0] a, input logic [15:0] b, input logic last);
      int n = 0;
      s_valid = 1'b1; s_a = a; s_b = b; s_last = last;
      while (!s_ready && n < 50) begin tick(); n++; end
      if (!s_ready) begin
         errors++;
         $display("FAIL send_timeout: s_ready=%0b after %0d cycles, required 1", s_ready, n);
      end
      tick();
      s_valid = 1'b0; s_a = '0; s_b = '0; s_last = 1'b0;
   endtask

   task automatic wait_result(output int n);
      n = 0;
      while (!m_valid && n < 50) begin tick(); n++; end
      checks++;
      if (m_valid !== 1'b1) begin
         errors++;
         $display("FAIL result_timeout: m_valid=%0b after %0d cycles, required 1", m_valid, n);
      end
   endtask

   task automatic accept();
      m_ready = 1'b1;
      tick();
      m_ready = 1'b0;
      checks++;
      if (m_valid !== 1'b0) begin
         errors++;
         $display("FAIL accept: m_valid=%0b, required 0", m_valid);
      end
   endtask

   task automatic test_reset();
      int n;
      reset = 1'b1;
      tick(); tick();
      reset = 1'b0;
      checks++;
      if ({s_ready, m_valid, m_data, m_count, dsp_a, dsp_b, dsp_mode} !== {1'b0, 1'b0, 16'h0, 16'h0, 16'h0, 16'h0, 3'b100}) begin
         errors++;
         $display("FAIL reset_vals: rdy=%0b mv=%0b md=%h mc=%0d a=%h b=%h mode=%b, required 0 0 0000 0 0000 0000 100",
                  s_ready, m_valid, m_data, m_count, dsp_a, dsp_b, dsp_mode);
      end
      // IDLE must not consume the waiting pair; CLEAR drives add mode with zero operands.
      s_valid = 1'b1; s_a = 16'h3C00; s_b = 16'h4000; s_last = 1'b1;
      #1;
      checks++;
      if (s_ready !== 1'b0 || dsp_a !== 16'h0) begin
         errors++;
         $display("FAIL idle_hold: s_ready=%0b dsp_a=%h, required 0 0000", s_ready, dsp_a);
      end
      tick();
      checks++;
      if (dsp_mode !== 3'b001 || s_ready !== 1'b0 || dsp_a !== 16'h0) begin
         errors++;
         $display("FAIL clear_mode: mode=%b s_ready=%0b dsp_a=%h, required 001 0 0000", dsp_mode, s_ready, dsp_a);
      end
      tick(); tick(); tick();
      checks++;
      if (s_ready !== 1'b1 || dsp_mode !== 3'b100 || dsp_a !== 16'h3C00 || dsp_b !== 16'h4000) begin
         errors++;
         $display("FAIL feed_pass: rdy=%0b mode=%b a=%h b=%h, required 1 100 3c00 4000", s_ready, dsp_mode, dsp_a, dsp_b);
      end
      tick();
      s_valid = 1'b0; s_a = '0; s_b = '0; s_last = 1'b0;
      wait_result(n);
      checks++;
      if (m_data !== 16'h4000 || m_count !== 16'd1) begin
         errors++;
         $display("FAIL first_vec: m_data=%h m_count=%0d, required 4000 1", m_data, m_count);
      end
      accept();
   endtask

   task automatic test_single_pair();
      int n;
      send_pair(16'h4000, 16'h4200, 1'b1);
      wait_result(n);
      checks++;
      if (n !== 3) begin
         errors++;
         $display("FAIL single_latency: cycles=%0d, required 3", n);
      end
      checks++;
      if (m_data !== 16'h4600 || m_count !== 16'd1 || s_ready !== 1'b0) begin
         errors++;
         $display("FAIL single_result: m_data=%h m_count=%0d s_ready=%0b, required 4600 1 0", m_data, m_count, s_ready);
      end
      accept();
   endtask

   task automatic test_back_to_back();
      int n;
      for (int i = 0; i < 4; i++) send_pair(16'h3C00, 16'h3C00, i == 3);
      wait_result(n);
      checks++;
      if (m_data !== 16'h4400 || m_count !== 16'd4) begin
         errors++;
         $display("FAIL b2b_result: m_data=%h m_count=%0d, required 4400 4", m_data, m_count);
      end
      accept();
   endtask

   task automatic test_gaps();
      int n;
      for (int i = 0; i < 4; i++) begin
         send_pair(16'h3C00, 16'h3C00, i == 3);
         if (i < 3) begin
            for (int g = 0; g < 2; g++) begin
               s_a = 16'h7BFF; s_b = 16'h7BFF;
               #1;
               checks++;
               if (dsp_a !== 16'h0 || dsp_b !== 16'h0 || s_ready !== 1'b1) begin
                  errors++;
                  $display("FAIL gap_zero: dsp_a=%h dsp_b=%h s_ready=%0b, required 0000 0000 1", dsp_a, dsp_b, s_ready);
               end
               tick();
            end
         end
      end
      wait_result(n);
      checks++;
      if (m_data !== 16'h4400 || m_count !== 16'd4) begin
         errors++;
         $display("FAIL gap_result: m_data=%h m_count=%0d, required 4400 4", m_data, m_count);
      end
      accept();
   endtask

   task automatic test_backpressure();
      int n;
      send_pair(16'h4000, 16'h4200, 1'b1);
      wait_result(n);
      for (int i = 0; i < 5; i++) begin
         tick();
         checks++;
         if (m_valid !== 1'b1 || m_data !== 16'h4600 || m_count !== 16'd1 || s_ready !== 1'b0) begin
            errors++;
            $display("FAIL bp_hold: cyc=%0d mv=%0b md=%h mc=%0d rdy=%0b, required 1 4600 1 0",
                     i, m_valid, m_data, m_count, s_ready);
         end
      end
      accept();
   endtask

   task automatic test_clear_between();
      int n;
      send_pair(16'h4000, 16'h4200, 1'b1);
      wait_result(n);
      accept();
      send_pair(16'h3C00, 16'h3C00, 1'b1);
      wait_result(n);
      checks++;
      if (m_data !== 16'h3C00 || m_count !== 16'd1) begin
         errors++;
         $display("FAIL clear_between: m_data=%h m_count=%0d, required 3c00 1", m_data, m_count);
      end
      accept();
   endtask

   task automatic test_reset_mid();
      int n;
      send_pair(16'h3C00, 16'h3C00, 1'b0);
      send_pair(16'h3C00, 16'h3C00, 1'b0);
      reset = 1'b1;
      tick();
      reset = 1'b0;
      for (int i = 0; i < 6; i++) begin
         checks++;
         if (m_valid !== 1'b0 || s_ready !== 1'b0 || dsp_mode !== 3'b100) begin
            errors++;
            $display("FAIL reset_mid: cyc=%0d mv=%0b rdy=%0b mode=%b, required 0 0 100", i, m_valid, s_ready, dsp_mode);
         end
         tick();
      end
      send_pair(16'h4000, 16'h4000, 1'b1);
      wait_result(n);
      checks++;
      if (m_data !== 16'h4400 || m_count !== 16'd1) begin
         errors++;
         $display("FAIL post_reset: m_data=%h m_count=%0d, required 4400 1", m_data, m_count);
      end
      accept();
   endtask

   initial begin
      reset = 1'b1; s_valid = 1'b0; s_a = '0; s_b = '0; s_last = 1'b0; m_ready = 1'b0;
      #1;
      test_reset();
      test_single_pair();
      test_back_to_back();
      test_gaps();
      test_backpressure();
      test_clear_between();
      test_reset_mid();
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached, required completion");
      $fatal(1, "watchdog");
   end

endmodule
